// File: rtl/recv_phy_deframer.sv
// recv_phy_deframer: receive-side MII deframer.
// Samples 4-bit PHY nibbles, strips the preamble and SFD, reassembles bytes low
// nibble first and emits a 24-bit control block at end of frame.
// Ports:
//   clk_phy       PHY nibble clock (only clock)
//   reset_n       asynchronous active-low reset
//   phy_data_in   receive nibble, low nibble of each byte first
//   phy_rx_dv     receive data valid
//   r_data_out    reassembled byte, valid with r_data_valid
//   r_data_valid  one-cycle strobe per delivered byte
//   r_ctrl_out    {count[11:0], 8'h00, odd_nibble, runt, giant, frame_ok}
//   r_frame_valid one-cycle strobe qualifying r_ctrl_out
//   r_drop_cnt    saturating count of dropped or bad frames
module recv_phy_deframer #(
  parameter int unsigned MIN_LEN = 64,
  parameter int unsigned MAX_LEN = 1518
) (
  input  logic        clk_phy,
  input  logic        reset_n,
  input  logic [3:0]  phy_data_in,
  input  logic        phy_rx_dv,
  output logic [7:0]  r_data_out,
  output logic        r_data_valid,
  output logic [23:0] r_ctrl_out,
  output logic        r_frame_valid,
  output logic [7:0]  r_drop_cnt
);

  localparam int unsigned NIB_W  = 4;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 12;
  localparam int unsigned CTRL_W = 24;
  localparam int unsigned DROP_W = 8;

  localparam logic [NIB_W-1:0]  NIB_PRE  = 4'h5;
  localparam logic [NIB_W-1:0]  NIB_SFD  = 4'hD;
  localparam logic [CNT_W-1:0]  MAX_CNT  = CNT_W'(MAX_LEN);
  localparam logic [CNT_W-1:0]  MIN_CNT  = CNT_W'(MIN_LEN);
  localparam logic [DROP_W-1:0] DROP_SAT = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PRE  = 2'd1,
    S_DATA = 2'd2,
    S_DROP = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic              phase_q, phase_d;
  logic [NIB_W-1:0]  low_q, low_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              giant_q, giant_d;

  logic [BYTE_W-1:0] data_d;
  logic              data_valid_d;
  logic [CTRL_W-1:0] ctrl_d;
  logic              frame_valid_d;
  logic [DROP_W-1:0] drop_d;
  logic              drop_inc;

  // End-of-frame status derived from the current frame state
  logic end_odd, end_runt, end_ok;
  assign end_odd  = phase_q;
  assign end_runt = (count_q < MIN_CNT);
  assign end_ok   = ~(end_odd | end_runt | giant_q);

  // State register
  always_ff @(posedge clk_phy or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (phy_rx_dv) begin
          state_d = (phy_data_in == NIB_PRE) ? S_PRE : S_DROP;
        end
      end
      S_PRE: begin
        if (!phy_rx_dv) begin
          state_d = S_IDLE;
        end else if (phy_data_in == NIB_SFD) begin
          state_d = S_DATA;
        end else if (phy_data_in != NIB_PRE) begin
          state_d = S_DROP;
        end
      end
      S_DATA: begin
        if (!phy_rx_dv) begin
          state_d = S_IDLE;
        end
      end
      S_DROP: begin
        if (!phy_rx_dv) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    phase_d       = phase_q;
    low_d         = low_q;
    count_d       = count_q;
    giant_d       = giant_q;
    data_d        = r_data_out;
    data_valid_d  = 1'b0;
    ctrl_d        = r_ctrl_out;
    frame_valid_d = 1'b0;
    drop_inc      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (phy_rx_dv && (phy_data_in != NIB_PRE)) begin
          drop_inc = 1'b1;
        end
      end
      S_PRE: begin
        if (!phy_rx_dv) begin
          drop_inc = 1'b1;
        end else if (phy_data_in == NIB_SFD) begin
          count_d = '0;
          phase_d = 1'b0;
          giant_d = 1'b0;
        end else if (phy_data_in != NIB_PRE) begin
          drop_inc = 1'b1;
        end
      end
      S_DATA: begin
        if (!phy_rx_dv) begin
          frame_valid_d = 1'b1;
          ctrl_d        = {count_q, 8'h00, end_odd, end_runt, giant_q, end_ok};
          drop_inc      = ~end_ok;
          phase_d       = 1'b0;
        end else if (!phase_q) begin
          low_d   = phy_data_in;
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          // Counter holds at the cap; excess bytes only mark the frame giant
          if (count_q < MAX_CNT) begin
            data_d       = {phy_data_in, low_q};
            data_valid_d = 1'b1;
            count_d      = count_q + CNT_W'(1);
          end else begin
            giant_d = 1'b1;
          end
        end
      end
      default: ;
    endcase

    drop_d = (drop_inc && (r_drop_cnt != DROP_SAT)) ? r_drop_cnt + DROP_W'(1) : r_drop_cnt;
  end

  // Datapath and output registers
  always_ff @(posedge clk_phy or negedge reset_n) begin
    if (!reset_n) begin
      phase_q       <= 1'b0;
      low_q         <= '0;
      count_q       <= '0;
      giant_q       <= 1'b0;
      r_data_out    <= '0;
      r_data_valid  <= 1'b0;
      r_ctrl_out    <= '0;
      r_frame_valid <= 1'b0;
      r_drop_cnt    <= '0;
    end else begin
      phase_q       <= phase_d;
      low_q         <= low_d;
      count_q       <= count_d;
      giant_q       <= giant_d;
      r_data_out    <= data_d;
      r_data_valid  <= data_valid_d;
      r_ctrl_out    <= ctrl_d;
      r_frame_valid <= frame_valid_d;
      r_drop_cnt    <= drop_d;
    end
  end

endmodule

// File: tb/tb_recv_phy_deframer.sv
// Bench for recv_phy_deframer: a default instance and a MAX_LEN=100 instance
// share the same PHY stimulus; expected bytes and control blocks are queued
// as frames are driven and popped when the DUTs strobe them.
module tb_recv_phy_deframer;

  localparam int unsigned G_MAX = 100;

  logic        clk_phy = 1'b0;
  logic        reset_n;
  logic [3:0]  phy_data_in;
  logic        phy_rx_dv;

  logic [7:0]  r_data_out,    r_data_out_g;
  logic        r_data_valid,  r_data_valid_g;
  logic [23:0] r_ctrl_out,    r_ctrl_out_g;
  logic        r_frame_valid, r_frame_valid_g;
  logic [7:0]  r_drop_cnt,    r_drop_cnt_g;

  recv_phy_deframer dut (
    .clk_phy       (clk_phy),
    .reset_n       (reset_n),
    .phy_data_in   (phy_data_in),
    .phy_rx_dv     (phy_rx_dv),
    .r_data_out    (r_data_out),
    .r_data_valid  (r_data_valid),
    .r_ctrl_out    (r_ctrl_out),
    .r_frame_valid (r_frame_valid),
    .r_drop_cnt    (r_drop_cnt)
  );

  recv_phy_deframer #(.MIN_LEN(64), .MAX_LEN(G_MAX)) dut_g (
    .clk_phy       (clk_phy),
    .reset_n       (reset_n),
    .phy_data_in   (phy_data_in),
    .phy_rx_dv     (phy_rx_dv),
    .r_data_out    (r_data_out_g),
    .r_data_valid  (r_data_valid_g),
    .r_ctrl_out    (r_ctrl_out_g),
    .r_frame_valid (r_frame_valid_g),
    .r_drop_cnt    (r_drop_cnt_g)
  );

  always #20 clk_phy = ~clk_phy;

  int tests = 0;
  int fails = 0;
  int exp_drop = 0;

  logic [7:0]  exp_bytes[$];
  logic [7:0]  exp_bytes_g[$];
  logic [23:0] exp_ctrl[$];
  logic [23:0] exp_ctrl_g[$];

  bit prev_dv   = 1'b0;
  bit prev_dv_g = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: compare every strobe against the queued expectation
  always @(negedge clk_phy) begin
    if (r_data_valid === 1'b1) begin
      check("byte_back_to_back", 32'(prev_dv), 32'd0);
      check("byte_with_frame", 32'(r_frame_valid), 32'd0);
      if (exp_bytes.size() == 0) check("unexpected_byte", 32'(r_data_valid), 32'd0);
      else check("byte", 32'(r_data_out), 32'(exp_bytes.pop_front()));
    end
    if (r_frame_valid === 1'b1) begin
      if (exp_ctrl.size() == 0) check("unexpected_frame", 32'(r_frame_valid), 32'd0);
      else check("ctrl", 32'(r_ctrl_out), 32'(exp_ctrl.pop_front()));
    end
    if (r_data_valid_g === 1'b1) begin
      check("g_byte_back_to_back", 32'(prev_dv_g), 32'd0);
      if (exp_bytes_g.size() == 0) check("g_unexpected_byte", 32'(r_data_valid_g), 32'd0);
      else check("g_byte", 32'(r_data_out_g), 32'(exp_bytes_g.pop_front()));
    end
    if (r_frame_valid_g === 1'b1) begin
      if (exp_ctrl_g.size() == 0) check("g_unexpected_frame", 32'(r_frame_valid_g), 32'd0);
      else check("g_ctrl", 32'(r_ctrl_out_g), 32'(exp_ctrl_g.pop_front()));
    end
    prev_dv   = (r_data_valid === 1'b1);
    prev_dv_g = (r_data_valid_g === 1'b1);
  end

  task automatic drive(input logic dv, input logic [3:0] nib);
    @(posedge clk_phy);
    #1;
    phy_rx_dv   = dv;
    phy_data_in = nib;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 4'h0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    drive(1'b1, b[3:0]);
    drive(1'b1, b[7:4]);
  endtask

  task automatic bump_drop();
    exp_drop = (exp_drop < 255) ? exp_drop + 1 : 255;
  endtask

  // pat 0: FF x4, 00 fill, FF x4; otherwise random bytes
  task automatic send_frame(input int n, input bit odd, input int pat,
                            input logic [23:0] ec, input logic [23:0] ecg);
    logic [7:0] b;
    repeat (15) drive(1'b1, 4'h5);
    drive(1'b1, 4'hD);
    for (int i = 0; i < n; i++) begin
      if (pat == 0) b = (i < 4 || i >= n - 4) ? 8'hFF : 8'h00;
      else          b = 8'($urandom);
      exp_bytes.push_back(b);
      if (i < int'(G_MAX)) exp_bytes_g.push_back(b);
      send_byte(b);
    end
    if (odd) drive(1'b1, 4'hA);
    exp_ctrl.push_back(ec);
    exp_ctrl_g.push_back(ecg);
    if (ec[0] == 1'b0) bump_drop();
    drive(1'b0, 4'h0);
  endtask

  task automatic wait_drain(input string tag);
    int k;
    k = 0;
    while (k < 300 && (exp_bytes.size() + exp_bytes_g.size() + exp_ctrl.size() + exp_ctrl_g.size()) != 0) begin
      @(negedge clk_phy);
      k++;
    end
    check(tag, 32'(exp_bytes.size() + exp_bytes_g.size() + exp_ctrl.size() + exp_ctrl_g.size()), 32'd0);
    idle(3);
  endtask

  initial begin
    reset_n     = 1'b0;
    phy_rx_dv   = 1'b0;
    phy_data_in = 4'h0;

    repeat (2) @(posedge clk_phy);
    #1;
    check("rst_data_out",    32'(r_data_out),    32'd0);
    check("rst_data_valid",  32'(r_data_valid),  32'd0);
    check("rst_ctrl_out",    32'(r_ctrl_out),    32'd0);
    check("rst_frame_valid", 32'(r_frame_valid), 32'd0);
    check("rst_drop_cnt",    32'(r_drop_cnt),    32'd0);
    @(negedge clk_phy);
    reset_n = 1'b1;
    idle(3);

    // Nominal 64-byte frame
    send_frame(64, 1'b0, 0, 24'h040001, 24'h040001);
    wait_drain("drain_nominal");
    check("drop_nominal", 32'(r_drop_cnt), 32'(exp_drop));

    // Runt
    send_frame(10, 1'b0, 1, 24'h00A004, 24'h00A004);
    wait_drain("drain_runt");
    check("drop_runt", 32'(r_drop_cnt), 32'(exp_drop));

    // Odd trailing nibble
    send_frame(64, 1'b1, 1, 24'h040008, 24'h040008);
    wait_drain("drain_odd");
    check("drop_odd", 32'(r_drop_cnt), 32'(exp_drop));

    // 120 bytes: fine for the default instance, giant for MAX_LEN=100
    send_frame(120, 1'b0, 1, 24'h078001, 24'h064002);
    wait_drain("drain_giant");
    check("drop_giant", 32'(r_drop_cnt), 32'(exp_drop));

    // Bad preamble 5,5,3,...
    drive(1'b1, 4'h5); drive(1'b1, 4'h5); drive(1'b1, 4'h3);
    drive(1'b1, 4'h5); drive(1'b1, 4'hD); drive(1'b1, 4'h0); drive(1'b1, 4'h0);
    drive(1'b0, 4'h0);
    bump_drop();
    idle(3);
    wait_drain("drain_bad_pre");
    check("drop_bad_pre", 32'(r_drop_cnt), 32'(exp_drop));

    // 300 bad frames saturate the drop counter
    repeat (300) begin
      drive(1'b1, 4'h3);
      drive(1'b0, 4'h0);
      bump_drop();
    end
    idle(3);
    check("drop_saturate", 32'(r_drop_cnt), 32'(exp_drop));
    check("g_drop_saturate", 32'(r_drop_cnt_g), 32'd255);

    // Reset mid-DATA while a byte strobe is live
    repeat (15) drive(1'b1, 4'h5);
    drive(1'b1, 4'hD);
    exp_bytes.push_back(8'h11); exp_bytes_g.push_back(8'h11); send_byte(8'h11);
    exp_bytes.push_back(8'h22); exp_bytes_g.push_back(8'h22); send_byte(8'h22);
    send_byte(8'h3C);
    @(posedge clk_phy);
    #2;
    check("pre_reset_valid", 32'(r_data_valid), 32'd1);
    reset_n = 1'b0;
    #1;
    check("midrst_data_out",    32'(r_data_out),    32'd0);
    check("midrst_data_valid",  32'(r_data_valid),  32'd0);
    check("midrst_ctrl_out",    32'(r_ctrl_out),    32'd0);
    check("midrst_frame_valid", 32'(r_frame_valid), 32'd0);
    check("midrst_drop_cnt",    32'(r_drop_cnt),    32'd0);
    exp_drop = 0;
    drive(1'b1, 4'h3);
    drive(1'b1, 4'h3);
    @(negedge clk_phy);
    reset_n = 1'b1;
    // Remaining nibbles of the interrupted frame hit IDLE as a bad start
    drive(1'b1, 4'h3); drive(1'b1, 4'h3); drive(1'b1, 4'h3);
    drive(1'b0, 4'h0);
    bump_drop();
    idle(6);
    wait_drain("drain_reset");
    check("drop_after_reset", 32'(r_drop_cnt), 32'(exp_drop));

    // Back-to-back nominal frames, one idle cycle apart
    send_frame(64, 1'b0, 0, 24'h040001, 24'h040001);
    send_frame(64, 1'b0, 0, 24'h040001, 24'h040001);
    wait_drain("drain_b2b");
    check("drop_b2b", 32'(r_drop_cnt), 32'(exp_drop));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/recv_phy_deframer.md
# recv_phy_deframer

Receive-side counterpart of the transmit path. It samples 4-bit MII-style nibbles from the PHY on `clk_phy`, strips and checks the preamble/SFD, and reassembles bytes low-nibble-first. It delivers bytes to the forwarding side with a per-byte strobe. At end of frame it emits a 24-bit control block in the same format the transmit path consumes: byte count in [23:12], status in [11:0]. It sits between the PHY pins and the receive clock-domain-crossing FIFO.

## Interface
- `MIN_LEN`, 64: minimum legal frame length in bytes; shorter frames are flagged runt.
- `MAX_LEN`, 1518: maximum bytes delivered per frame; must be ≤ 4095.
- `clk_phy`  in  1  PHY nibble clock, 25 MHz. This is the block's only clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `phy_data_in`  in  4  receive nibble; low nibble of each byte arrives first.
- `phy_rx_dv`  in  1  receive data valid; high for the preamble, the SFD and all data nibbles.
- `r_data_out`  out  8  reassembled byte; meaningful only while `r_data_valid` is high.
- `r_data_valid`  out  1  one-cycle strobe per delivered byte.
- `r_ctrl_out`  out  24  control block: [23:12] byte count, [11:4] zero, [3] odd_nibble, [2] runt, [1] giant, [0] frame_ok.
- `r_frame_valid`  out  1  one-cycle strobe; `r_ctrl_out` is valid only in this cycle.
- `r_drop_cnt`  out  8  saturating count of dropped or bad frames.

## Operation
- States are IDLE, PRE, DATA and DROP.
- **IDLE**
  - `phy_rx_dv`=1 and nibble=0x5 → PRE.
  - `phy_rx_dv`=1 and any other nibble → DROP; `r_drop_cnt`++.
- **PRE**
  - nibble 0x5 with `phy_rx_dv`=1 → stay in PRE; any number of 0x5 nibbles is accepted.
  - nibble 0xD → DATA; clear the byte counter, nibble phase and giant flag.
  - any other nibble → DROP; `r_drop_cnt`++.
  - `phy_rx_dv`=0 → IDLE; `r_drop_cnt`++; no frame strobe.
- **DATA**
  - Phase 0: latch the nibble as the low half.
  - Phase 1: form {nibble, low}.
    - If count < `MAX_LEN`: drive `r_data_out`, pulse `r_data_valid`, count++.
    - Otherwise: suppress the byte and set the giant flag.
  - `phy_rx_dv`=0 ends the frame; go to IDLE and pulse `r_frame_valid` with `r_ctrl_out` =
    - {count[11:0], 8'h00, phase==1, count<`MIN_LEN`, giant, ok};
    - ok = 1 only if all of odd_nibble, runt and giant are clear.
  - If ok=0, `r_drop_cnt`++.
- **DROP**: wait for `phy_rx_dv`=0, then → IDLE. No bytes and no frame strobe are produced.
- `r_drop_cnt` saturates at 255 and never wraps.
- The byte counter is 12 bits and holds at `MAX_LEN`, so it never wraps.

## Timing
- All outputs are registered.
- Reset values:
  - `r_data_out`=0, `r_data_valid`=0, `r_ctrl_out`=0, `r_frame_valid`=0, `r_drop_cnt`=0.
  - state = IDLE, phase = 0, count = 0.
- Byte latency: `r_data_valid` rises in the cycle after the high nibble is sampled. Consecutive bytes are strobed every 2 cycles, with no back-to-back strobes.
- Frame end: `r_frame_valid` rises in the cycle after `phy_rx_dv` is first sampled low in DATA. It never coincides with `r_data_valid`.
- IDLE accepts a new preamble nibble in the same cycle that `r_frame_valid` is high, so zero interframe gap is tolerated.
- SFD latency: the first data nibble is the one sampled in the cycle after 0xD.
- Reset mid-frame:
  - All outputs clear immediately, asynchronously; the partial frame is discarded without a strobe.
  - After release, a frame already in progress is treated by the IDLE rules.
- No backpressure. The downstream side must accept one byte every 2 cycles.

## Test plan
- **Nominal frame:** 15×0x5, 0xD, then 64 bytes (FF×4, 00×56, FF×4) sent low nibble first, then `phy_rx_dv` low.
  - Expect 64 `r_data_valid` pulses with matching bytes.
  - Expect one `r_frame_valid` with `r_ctrl_out`=24'h040001.
  - `r_drop_cnt`=0.
- **Runt:** valid preamble/SFD followed by 10 bytes.
  - Expect 10 byte strobes and `r_ctrl_out`=24'h00A004.
  - `r_drop_cnt`=1.
- **Odd nibble:** 64 bytes plus one extra nibble.
  - Expect 64 strobes and `r_ctrl_out`=24'h040008.
  - `r_drop_cnt`++.
- **Giant:** with `MAX_LEN`=100, send 120 bytes.
  - Expect exactly 100 strobes and `r_ctrl_out`=24'h064002.
- **Bad preamble:** frame starting 0x5,0x5,0x3,….
  - Expect no byte or frame strobes and `r_drop_cnt`++.
  - Then send 300 bad frames: `r_drop_cnt` holds at 255.
- **Reset and back-to-back:**
  - Assert `reset_n`=0 mid-DATA: all outputs are 0 that cycle, and no frame strobe follows the release.
  - Send two nominal frames separated by a 1-cycle `phy_rx_dv` low: expect two control blocks, both 24'h040001.
